// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the MM:SS stopwatch: BCD digit limits,
// anode patterns and a two-digit BCD incrementer.
package stopwatch_pkg;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  localparam logic [3:0] AN_SEC_ONES = 4'b1110;
  localparam logic [3:0] AN_SEC_TENS = 4'b1101;
  localparam logic [3:0] AN_MIN_ONES = 4'b1011;
  localparam logic [3:0] AN_MIN_TENS = 4'b0111;

  typedef enum logic [1:0] {
    DIG_SEC_ONES,
    DIG_SEC_TENS,
    DIG_MIN_ONES,
    DIG_MIN_TENS
  } digit_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic bcd2_at_max(bcd2_t v);
    return (v.tens == TENS_MAX) && (v.ones == ONES_MAX);
  endfunction

  // Counts 00..59 and wraps to 00; the caller decides about carries.
  function automatic bcd2_t bcd2_inc(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == ONES_MAX) begin
      r.ones = 4'd0;
      r.tens = (v.tens == TENS_MAX) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [3:0] anode_for(digit_e d);
    logic [3:0] pat;
    case (d)
      DIG_SEC_ONES: pat = AN_SEC_ONES;
      DIG_SEC_TENS: pat = AN_SEC_TENS;
      DIG_MIN_ONES: pat = AN_MIN_ONES;
      default:      pat = AN_MIN_TENS;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the accepted level
// follows the input only after DEBOUNCE_CYC consecutive differing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously
  // so every flop, including the synchronizer, starts from a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with pause/clear buttons, a 2 Hz field-adjust mode and a
// rotating one-cold anode select for a four-digit multiplexed display.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int DIV_1HZ      = 100_000_000,
  parameter int DIV_ADJ      = 50_000_000,
  parameter int DIV_SCAN     = 100_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause_btn,
  input  logic       clr_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] an
);

  localparam int W_RUN  = $clog2(DIV_1HZ);
  localparam int W_ADJ  = $clog2(DIV_ADJ);
  localparam int W_SCAN = $clog2(DIV_SCAN);

  logic              pause_level, pause_level_q, clr_level, paused;
  logic [W_RUN-1:0]  run_cnt;
  logic [W_ADJ-1:0]  adj_cnt;
  logic [W_SCAN-1:0] scan_cnt;
  logic              run_tick, adj_tick, scan_tick;
  bcd2_t             sec, min;
  digit_e            scan_digit;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause_db (
    .clk(clk), .rst_n(rst_n), .btn(pause_btn), .level(pause_level)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_db (
    .clk(clk), .rst_n(rst_n), .btn(clr_btn), .level(clr_level)
  );

  assign run_tick  = (run_cnt  == W_RUN'(DIV_1HZ - 1));
  assign adj_tick  = (adj_cnt  == W_ADJ'(DIV_ADJ - 1));
  assign scan_tick = (scan_cnt == W_SCAN'(DIV_SCAN - 1));

  // The run prescaler is parked at 0 during clear so the first second after
  // release is a full DIV_1HZ cycles long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      adj_cnt  <= '0;
      scan_cnt <= '0;
    end else begin
      run_cnt  <= (clr_level || run_tick) ? '0 : run_cnt + 1'b1;
      adj_cnt  <= adj_tick  ? '0 : adj_cnt + 1'b1;
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_level_q <= 1'b0;
      paused        <= 1'b0;
    end else begin
      pause_level_q <= pause_level;
      if (pause_level && !pause_level_q) paused <= !paused;
    end
  end

  // Clear beats adjust beats run; adjust wraps a field without carrying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec <= '0;
      min <= '0;
    end else if (clr_level) begin
      sec <= '0;
      min <= '0;
    end else if (adj) begin
      if (adj_tick) begin
        if (sel) sec <= bcd2_inc(sec);
        else     min <= bcd2_inc(min);
      end
    end else if (run_tick && !paused) begin
      sec <= bcd2_inc(sec);
      if (bcd2_at_max(sec)) min <= bcd2_inc(min);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_digit <= DIG_SEC_ONES;
    end else if (scan_tick) begin
      scan_digit <= digit_e'(scan_digit + 2'd1);
    end
  end

  assign an       = anode_for(scan_digit);
  assign sec_ones = sec.ones;
  assign sec_tens = sec.tens;
  assign min_ones = min.ones;
  assign min_tens = min.tens;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with small dividers: an adjust/run
// vector table followed by pause, bounce, clear, scan and reset sequences.
module tb_stopwatch_counter;

  logic       clk, rst_n, pause_btn, clr_btn, adj, sel;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, an;
  logic [15:0] digits;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    logic        adj;
    logic        sel;
    int          adv;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  stopwatch_counter #(
    .DIV_1HZ(10), .DIV_ADJ(5), .DIV_SCAN(4), .DEBOUNCE_CYC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause_btn(pause_btn), .clr_btn(clr_btn),
    .adj(adj), .sel(sel), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .an(an)
  );

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    tick(3);
    pause_btn = 1'b0;
  endtask

  function automatic logic [3:0] exp_an(input int e);
    case ((e / 4) % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  initial begin
    // {adj, sel, edges to advance, expected MM:SS}; edge count is cumulative from reset release
    vecs[0]  = '{1'b1, 1'b1,   5, 16'h0001};
    vecs[1]  = '{1'b1, 1'b1,   4, 16'h0001};
    vecs[2]  = '{1'b1, 1'b1,   1, 16'h0002};
    vecs[3]  = '{1'b1, 1'b1, 280, 16'h0058};
    vecs[4]  = '{1'b1, 1'b1,   5, 16'h0059};
    vecs[5]  = '{1'b1, 1'b1,   5, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0,   5, 16'h0100};
    vecs[7]  = '{1'b1, 1'b0, 290, 16'h5900};
    vecs[8]  = '{1'b1, 1'b0,   5, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 295, 16'h5900};
    vecs[10] = '{1'b1, 1'b1, 290, 16'h5958};
    vecs[11] = '{1'b0, 1'b1,   4, 16'h5958};
    vecs[12] = '{1'b0, 1'b1,   1, 16'h5959};
    vecs[13] = '{1'b0, 1'b1,   9, 16'h5959};
    vecs[14] = '{1'b0, 1'b1,   1, 16'h0000};
    vecs[15] = '{1'b0, 1'b0,  10, 16'h0001};

    rst_n = 1'b0; pause_btn = 1'b0; clr_btn = 1'b0; adj = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_digits", digits, 16'h0000);
    check("reset_an", {12'h0, an}, 16'h000e);
    rst_n  = 1'b1;
    edge_n = 0;

    for (int i = 0; i < 16; i++) begin
      adj = vecs[i].adj;
      sel = vecs[i].sel;
      tick(vecs[i].adv);
      check($sformatf("vec%0d_digits", i), digits, vecs[i].exp);
      check($sformatf("vec%0d_an", i), {12'h0, an}, {12'h0, exp_an(edge_n)});
    end

    // Pause at 00:03, hold through five run strobes, resume.
    tick(21);
    check("pause_start", digits, 16'h0003);
    press_pause();
    tick(7);
    check("paused_early", digits, 16'h0003);
    tick(40);
    check("paused_5_strobes", digits, 16'h0003);
    press_pause();
    tick(5);
    check("resume_before_strobe", digits, 16'h0003);
    tick(1);
    check("resume_counts", digits, 16'h0004);

    // Bouncing pause button must not toggle the paused flag.
    for (int k = 0; k < 20; k++) begin
      pause_btn = ~pause_btn;
      tick(1);
    end
    pause_btn = 1'b0;
    check("bounce_still_running", digits, 16'h0006);
    tick(10);
    check("bounce_next_strobe", digits, 16'h0007);

    // Clear held with adjust asserted, then release and time the first increment.
    adj     = 1'b1;
    clr_btn = 1'b1;
    tick(10);
    check("clear_over_adjust", digits, 16'h0000);
    tick(15);
    check("clear_held", digits, 16'h0000);
    tick(5);
    clr_btn = 1'b0;
    adj     = 1'b0;
    tick(14);
    check("clear_release_wait", digits, 16'h0000);
    tick(1);
    check("clear_release_first", digits, 16'h0001);

    // Scan rotation, then an asynchronous reset in the middle of a scan step.
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check($sformatf("scan_%0d", k), {12'h0, an}, {12'h0, exp_an(edge_n)});
    end
    rst_n = 1'b0;
    #1;
    check("async_reset_digits", digits, 16'h0000);
    check("async_reset_an", {12'h0, an}, 16'h000e);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    tick(3);
    check("post_reset_an_hold", {12'h0, an}, 16'h000e);
    tick(1);
    check("post_reset_an_step", {12'h0, an}, 16'h000d);
    tick(5);
    check("post_reset_digits_wait", digits, 16'h0000);
    tick(1);
    check("post_reset_first_sec", digits, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have parameter DIV_1HZ, default 100_000_000, clk cycles per run-count tick.
REQ-002 The block SHALL have parameter DIV_ADJ, default 50_000_000, clk cycles per adjust tick (2 Hz).
REQ-003 The block SHALL have parameter DIV_SCAN, default 100_000, clk cycles per anode step.
REQ-004 The block SHALL have parameter DEBOUNCE_CYC, default 1_000_000, stable cycles required to accept a button level.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port pause_btn, input, 1 bit: raw, asynchronous pause/resume pushbutton.
REQ-008 The block SHALL have port clr_btn, input, 1 bit: raw, asynchronous clear pushbutton.
REQ-009 The block SHALL have port adj, input, 1 bit: adjust-mode switch.
REQ-010 The block SHALL have port sel, input, 1 bit: adjust field select; 0 = minutes, 1 = seconds.
REQ-011 The block SHALL have ports sec_ones, sec_tens, min_ones, min_tens, each output, 4 bits, BCD.
REQ-012 The block SHALL have port an, output, 4 bits: one-cold anode select.

Function
REQ-013 Three free-running prescalers SHALL each emit a one-cycle strobe on the cycle their count equals DIV_x-1, then wrap to 0.
REQ-014 Each strobe's counter effect SHALL be registered on that edge and visible on outputs the next cycle.
REQ-015 Each button SHALL pass a 2-flop synchronizer, then debounce: the accepted level changes only after DEBOUNCE_CYC consecutive equal samples.
REQ-016 Pause SHALL toggle the internal paused flag on each accepted 0->1 transition of pause_btn; holding the button SHALL NOT re-toggle it.
REQ-017 Run mode (adj=0, paused=0): each 1 Hz strobe SHALL increment MM:SS. sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; 59:59 SHALL wrap to 00:00.
REQ-018 While paused=1 and adj=0, the 1 Hz strobe SHALL NOT change the digits.
REQ-019 Adjust mode (adj=1): the 1 Hz increment SHALL be suspended.
REQ-020 Adjust mode: each DIV_ADJ strobe SHALL increment the field selected by sel by one; 59 SHALL wrap to 00 with no carry into the other field.
REQ-021 Adjust mode SHALL operate regardless of the paused flag; adjust SHALL NOT alter the paused flag.
REQ-022 While the accepted clr_btn level is 1, all four digits SHALL be 0 on the next cycle and the 1 Hz prescaler SHALL be held at 0.
REQ-023 Priority on the same cycle SHALL be clear > adjust > run.
REQ-024 Clearing SHALL NOT alter the paused flag.
REQ-025 The first run increment after clear releases SHALL occur DIV_1HZ cycles later.
REQ-026 Tens digits SHALL never exceed 5 and ones digits SHALL never exceed 9.
REQ-027 an SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per scan strobe; exactly one bit SHALL be 0 at all times.
REQ-028 an SHALL select sec_ones, sec_tens, min_ones, min_tens respectively.

Reset
REQ-029 rst_n low SHALL asynchronously force all digits to 0, an to 1110, paused to 0, all prescalers to 0, synchronizers to 0, and debounced levels to 0.
REQ-030 Reset assertion mid-press or mid-count SHALL discard the partial debounce and prescale state.
REQ-031 Operation SHALL resume on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package stopwatch_pkg SHALL hold the BCD limits (9, 5) and the four anode patterns.
REQ-033 Sub-module btn_debounce SHALL contain the synchronizer and debounce counter, parameterized by DEBOUNCE_CYC, and SHALL be instantiated twice.
REQ-034 The target implementation size SHALL be 150-300 lines.

Verification (DIV_1HZ=10, DIV_ADJ=5, DIV_SCAN=4, DEBOUNCE_CYC=3)
REQ-035 Scenario, run wrap: preload via adjust to 59:58, adj=0 -> after 2 run strobes the digits read 00:00.
REQ-036 Scenario, adjust: adj=1, sel=1, starting at 00:58 -> the 2 Hz strobes give 00:59, then 00:00, with minutes unchanged; no run increments meanwhile.
REQ-037 Scenario, pause: press pause (held 3 cycles) at 00:03 -> digits hold 00:03 across 5 strobes; a second press resumes counting to 00:04.
REQ-038 Scenario, bounce: pause_btn toggling every cycle for 20 cycles -> the paused flag is unchanged.
REQ-039 Scenario, clear with simultaneous adjust: clr held with adj=1 -> digits stay 00:00; after clear releases and adj=0, the first increment arrives exactly 10 cycles later.
REQ-040 Scenario, scan and reset: an steps every 4 cycles through the 4 patterns; rst_n pulsed low mid-step -> an=1110 and digits 00:00 immediately.
